// File: rtl/host_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : host_mem_responder                                           |
// | Description : AXI4 memory-mapped responder backed by a local dual-port RAM.|
// |               Serves INCR bursts with independent read and write FSMs,     |
// |               one outstanding burst per direction, and burst-framing check.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module host_mem_responder #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 48,
   parameter int ID_WIDTH   = 9,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   // read address
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [ID_WIDTH-1:0]     arid,
   // read data
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic [ID_WIDTH-1:0]     rid,
   // write address
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [ID_WIDTH-1:0]     awid,
   // write data
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   // write response
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   output logic [ID_WIDTH-1:0]     bid
);

   localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int         OFFSET      = $clog2(STRB_WIDTH);
   localparam int         DEPTH       = 2 ** DEPTH_LOG2;
   localparam logic [2:0] FULL_SIZE   = 3'(OFFSET);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_SEND = 2'd2} rstate_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

   // RAM storage; contents deliberately have no reset
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // read channel state
   rstate_t               rstate_q, rstate_d;
   logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;
   logic [7:0]            rlen_q, rlen_d;
   logic [7:0]            rcnt_q, rcnt_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic                  rbad_q, rbad_d;
   logic [DATA_WIDTH-1:0] rdata_q;

   // write channel state; beat count is one bit wider than len so overruns stay visible
   wstate_t               wstate_q, wstate_d;
   logic [DEPTH_LOG2-1:0] widx_q, widx_d;
   logic [7:0]            wlen_q, wlen_d;
   logic [8:0]            wcnt_q, wcnt_d;
   logic [ID_WIDTH-1:0]   wid_q, wid_d;
   logic                  wbad_q, wbad_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  wr_en;

   // only the word-index slice of each address is meaningful
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{araddr, awaddr};

   // read FSM next-state: capture AR, alternate fetch/send until the last beat
   always_comb begin
      rstate_d = rstate_q;
      ridx_d   = ridx_q;
      rlen_d   = rlen_q;
      rcnt_d   = rcnt_q;
      rid_d    = rid_q;
      rbad_d   = rbad_q;
      case (rstate_q)
         R_IDLE: begin
            if (arvalid) begin
               ridx_d   = araddr[OFFSET +: DEPTH_LOG2];
               rlen_d   = arlen;
               rcnt_d   = 8'd0;
               rid_d    = arid;
               rbad_d   = (arsize != FULL_SIZE);
               rstate_d = R_FETCH;
            end
         end
         R_FETCH: rstate_d = R_SEND;
         R_SEND: begin
            if (rready) begin
               if (rcnt_q == rlen_q) begin
                  rstate_d = R_IDLE;
               end else begin
                  ridx_d   = ridx_q + 1'b1;
                  rcnt_d   = rcnt_q + 8'd1;
                  rstate_d = R_FETCH;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // read FSM registers; the data register is loaded during the fetch cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rstate_q <= R_IDLE;
         ridx_q   <= '0;
         rlen_q   <= '0;
         rcnt_q   <= '0;
         rid_q    <= '0;
         rbad_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rstate_q <= rstate_d;
         ridx_q   <= ridx_d;
         rlen_q   <= rlen_d;
         rcnt_q   <= rcnt_d;
         rid_q    <= rid_d;
         rbad_q   <= rbad_d;
         if (rstate_q == R_FETCH) begin
            rdata_q <= rbad_q ? '0 : mem_q[ridx_q];
         end
      end
   end

   assign arready = (rstate_q == R_IDLE);
   assign rvalid  = (rstate_q == R_SEND);
   assign rlast   = rvalid && (rcnt_q == rlen_q);
   assign rresp   = rbad_q ? RESP_SLVERR : RESP_OKAY;
   assign rid     = rid_q;
   assign rdata   = rdata_q;

   // write FSM next-state: accept every beat, store only in-range beats of a good burst
   always_comb begin
      wstate_d = wstate_q;
      widx_d   = widx_q;
      wlen_d   = wlen_q;
      wcnt_d   = wcnt_q;
      wid_d    = wid_q;
      wbad_d   = wbad_q;
      bresp_d  = bresp_q;
      wr_en    = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (awvalid) begin
               widx_d   = awaddr[OFFSET +: DEPTH_LOG2];
               wlen_d   = awlen;
               wcnt_d   = 9'd0;
               wid_d    = awid;
               wbad_d   = (awsize != FULL_SIZE);
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               wr_en  = !wbad_q && (wcnt_q <= {1'b0, wlen_q});
               widx_d = widx_q + 1'b1;
               // saturate so very long overruns can never wrap back to a legal total
               if (wcnt_q != 9'h1FF) begin
                  wcnt_d = wcnt_q + 9'd1;
               end
               if (wlast) begin
                  // this beat brings the total to wcnt_q+1, which must equal len+1
                  bresp_d  = (wbad_q || (wcnt_q != {1'b0, wlen_q})) ? RESP_SLVERR : RESP_OKAY;
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // write FSM registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wstate_q <= W_IDLE;
         widx_q   <= '0;
         wlen_q   <= '0;
         wcnt_q   <= '0;
         wid_q    <= '0;
         wbad_q   <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         wstate_q <= wstate_d;
         widx_q   <= widx_d;
         wlen_q   <= wlen_d;
         wcnt_q   <= wcnt_d;
         wid_q    <= wid_d;
         wbad_q   <= wbad_d;
         bresp_q  <= bresp_d;
      end
   end

   assign awready = (wstate_q == W_IDLE);
   assign wready  = (wstate_q == W_DATA);
   assign bvalid  = (wstate_q == W_RESP);
   assign bresp   = bresp_q;
   assign bid     = wid_q;

   // RAM write port with byte enables; read-first because the read side samples the old word
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb[b]) begin
               mem_q[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_host_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_host_mem_responder                                        |
// | Description : Directed bench with a queue scoreboard and an independent    |
// |               monitor for the R and B channels.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_host_mem_responder;
   localparam int DW = 512;
   localparam int AW = 48;
   localparam int IW = 9;
   localparam int DL = 10;
   localparam int SW = DW / 8;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          arvalid = 1'b0, arready;
   logic [AW-1:0] araddr = '0;
   logic [7:0]    arlen = '0;
   logic [2:0]    arsize = '0;
   logic [IW-1:0] arid = '0;
   logic          rvalid, rready = 1'b0;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic [IW-1:0] rid;
   logic          awvalid = 1'b0, awready;
   logic [AW-1:0] awaddr = '0;
   logic [7:0]    awlen = '0;
   logic [2:0]    awsize = '0;
   logic [IW-1:0] awid = '0;
   logic          wvalid = 1'b0, wready;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          wlast = 1'b0;
   logic          bvalid, bready = 1'b0;
   logic [1:0]    bresp;
   logic [IW-1:0] bid;

   host_mem_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ID_WIDTH   (IW),
      .DEPTH_LOG2 (DL)
   ) dut (
      .clk     (clk),     .reset_n (reset_n),
      .arvalid (arvalid), .arready (arready), .araddr (araddr), .arlen (arlen),
      .arsize  (arsize),  .arid    (arid),
      .rvalid  (rvalid),  .rready  (rready),  .rdata  (rdata),  .rresp (rresp),
      .rlast   (rlast),   .rid     (rid),
      .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awlen (awlen),
      .awsize  (awsize),  .awid    (awid),
      .wvalid  (wvalid),  .wready  (wready),  .wdata  (wdata),  .wstrb (wstrb),
      .wlast   (wlast),
      .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp),  .bid   (bid)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    resp;
      logic [IW-1:0] id;
      logic          last;
   } rexp_t;
   typedef struct {
      logic [1:0]    resp;
      logic [IW-1:0] id;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   int    total = 0;
   int    bad   = 0;
   logic  rr_mode = 1'b0;   // 1: random rready
   logic  rr_level = 1'b1;  // rready level when not random

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // single owner of rready
   initial forever begin
      @(posedge clk);
      #2;
      rready = rr_mode ? 1'($urandom_range(0, 1)) : rr_level;
   end

   // monitor: stability while stalled, scoreboard pop on each handshake
   logic          pr_v = 1'b0, pr_r = 1'b0, pb_v = 1'b0, pb_r = 1'b0;
   logic [DW-1:0] p_d;
   logic [11:0]   p_rctl;
   logic [10:0]   p_bctl;
   rexp_t         me;
   bexp_t         mb;
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         pr_v = 1'b0;
         pb_v = 1'b0;
      end else begin
         if (pr_v && !pr_r) begin
            chk("r_hold_valid", DW'(rvalid), DW'(1));
            chk("r_hold_data", rdata, p_d);
            chk("r_hold_ctl", DW'({rresp, rid, rlast}), DW'(p_rctl));
         end
         if (pb_v && !pb_r) begin
            chk("b_hold_valid", DW'(bvalid), DW'(1));
            chk("b_hold_ctl", DW'({bresp, bid}), DW'(p_bctl));
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               chk("r_unexpected_beat", DW'(rvalid), DW'(0));
            end else begin
               me = rq.pop_front();
               chk("r_data", rdata, me.d);
               chk("r_resp", DW'(rresp), DW'(me.resp));
               chk("r_id", DW'(rid), DW'(me.id));
               chk("r_last", DW'(rlast), DW'(me.last));
            end
         end
         if (bvalid && bready) begin
            if (bq.size() == 0) begin
               chk("b_unexpected", DW'(bvalid), DW'(0));
            end else begin
               mb = bq.pop_front();
               chk("b_resp", DW'(bresp), DW'(mb.resp));
               chk("b_id", DW'(bid), DW'(mb.id));
            end
         end
         pr_v   = rvalid;
         pr_r   = rready;
         p_d    = rdata;
         p_rctl = {rresp, rid, rlast};
         pb_v   = bvalid;
         pb_r   = bready;
         p_bctl = {bresp, bid};
      end
   end

   task automatic exp_r(input logic [DW-1:0] d, input logic [1:0] resp,
                        input logic [IW-1:0] id, input logic last);
      rexp_t e;
      e.d = d; e.resp = resp; e.id = id; e.last = last;
      rq.push_back(e);
   endtask

   task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [IW-1:0] id, input logic [2:0] size,
                              input int nbeats, input logic [DW-1:0] base,
                              input int sbeat, input logic [SW-1:0] sval,
                              input logic [1:0] eresp, input int bdelay);
      bexp_t be;
      int    n;
      logic  hs;
      be.resp = eresp; be.id = id;
      bq.push_back(be);
      awaddr = addr; awlen = len; awid = id; awsize = size; awvalid = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 50) begin
         @(negedge clk); hs = awready; tick(); n++;
      end
      awvalid = 1'b0;
      chk("aw_accept", DW'(hs), DW'(1));
      for (int b = 0; b < nbeats; b++) begin
         wvalid = 1'b1;
         wdata  = base ^ DW'(b);
         wstrb  = (b == sbeat) ? sval : '1;
         wlast  = (b == nbeats - 1);
         n = 0; hs = 1'b0;
         while (!hs && n < 50) begin
            @(negedge clk);
            hs = wready;
            if (b == 0 && n == 0) chk("wready_after_aw", DW'(wready), DW'(1));
            tick(); n++;
         end
         if (!hs) chk("w_accept", DW'(hs), DW'(1));
      end
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge clk);
      chk("bvalid_after_wlast", DW'(bvalid), DW'(1));
      tick();
      repeat (bdelay) tick();
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("b_consumed", DW'(bq.size()), DW'(0));
      n = 0;
      while (!awready && n < 20) begin tick(); n++; end
      chk("awready_back", DW'(awready), DW'(1));
   endtask

   task automatic issue_ar(input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id, input logic [2:0] size);
      int   n;
      logic hs;
      araddr = addr; arlen = len; arid = id; arsize = size; arvalid = 1'b1;
      n = 0; hs = 1'b0;
      while (!hs && n < 50) begin
         @(negedge clk); hs = arready; tick(); n++;
      end
      arvalid = 1'b0;
      chk("ar_accept", DW'(hs), DW'(1));
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [IW-1:0] id, input logic [2:0] size, input logic timing);
      int n;
      issue_ar(addr, len, id, size);
      if (timing) begin
         @(negedge clk); chk("rvalid_at_n1", DW'(rvalid), DW'(0));
         @(negedge clk); chk("rvalid_at_n2", DW'(rvalid), DW'(1));
      end
      n = 0;
      while ((rq.size() != 0 || !arready) && n < 500) begin tick(); n++; end
      chk("read_complete", DW'(rq.size()), DW'(0));
      chk("arready_back", DW'(arready), DW'(1));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      // reset state
      @(negedge clk);
      chk("rst_arready", DW'(arready), DW'(1));
      chk("rst_awready", DW'(awready), DW'(1));
      chk("rst_rvalid", DW'(rvalid), DW'(0));
      chk("rst_wready", DW'(wready), DW'(0));
      chk("rst_bvalid", DW'(bvalid), DW'(0));
      chk("rst_rlast", DW'(rlast), DW'(0));
      chk("rst_resp_ids", DW'({rresp, bresp, rid, bid}), DW'(0));
      chk("rst_rdata", rdata, DW'(0));
      tick();
      reset_n = 1'b1;
      tick();

      // single beat
      write_burst(48'h40, 8'd0, 9'd5, 3'd6, 1, {64{8'hA5}}, -1, '1, OKAY, 0);
      exp_r({64{8'hA5}}, OKAY, 9'd3, 1'b1);
      do_read(48'h40, 8'd0, 9'd3, 3'd6, 1'b1);

      // burst with a partial strobe on beat 2
      write_burst(48'h1000, 8'd3, 9'd1, 3'd6, 4, {64{8'hFF}}, -1, '1, OKAY, 0);
      write_burst(48'h1000, 8'd3, 9'd2, 3'd6, 4, DW'(0), 2, 64'h1, OKAY, 0);
      exp_r(DW'(0), OKAY, 9'd4, 1'b0);
      exp_r(DW'(1), OKAY, 9'd4, 1'b0);
      exp_r({{63{8'hFF}}, 8'h02}, OKAY, 9'd4, 1'b0);
      exp_r(DW'(3), OKAY, 9'd4, 1'b1);
      do_read(48'h1000, 8'd3, 9'd4, 3'd6, 1'b0);

      // wrap at the last index, delayed bready, random rready
      write_burst(48'hFFC0, 8'd1, 9'h1FF, 3'd6, 2, {64{8'h3C}}, -1, '1, OKAY, 5);
      rr_mode = 1'b1;
      exp_r({64{8'h3C}}, OKAY, 9'h155, 1'b0);
      exp_r({{63{8'h3C}}, 8'h3D}, OKAY, 9'h155, 1'b1);
      do_read(48'hFFC0, 8'd1, 9'h155, 3'd6, 1'b0);
      exp_r({{63{8'h3C}}, 8'h3D}, OKAY, 9'h0AA, 1'b1);
      do_read(48'h1_0000, 8'd0, 9'h0AA, 3'd6, 1'b0);

      // framing errors
      write_burst(48'h2000, 8'd3, 9'd10, 3'd6, 4, {64{8'h77}}, -1, '1, OKAY, 0);
      write_burst(48'h2000, 8'd3, 9'd11, 3'd6, 2, {64{8'h11}}, -1, '1, SLVERR, 0);
      exp_r({64{8'h11}}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h11}}, 8'h10}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h77}}, 8'h75}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h77}}, 8'h74}, OKAY, 9'd12, 1'b1);
      do_read(48'h2000, 8'd3, 9'd12, 3'd6, 1'b0);
      write_burst(48'h2000, 8'd1, 9'd13, 3'd6, 4, {64{8'h22}}, -1, '1, SLVERR, 2);
      exp_r({64{8'h22}}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h22}}, 8'h23}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h77}}, 8'h75}, OKAY, 9'd12, 1'b0);
      exp_r({{63{8'h77}}, 8'h74}, OKAY, 9'd12, 1'b1);
      do_read(48'h2000, 8'd3, 9'd12, 3'd6, 1'b0);

      // bad size on both channels
      write_burst(48'h2000, 8'd0, 9'd14, 3'd3, 1, {64{8'h99}}, -1, '1, SLVERR, 0);
      exp_r({64{8'h22}}, OKAY, 9'd15, 1'b1);
      do_read(48'h2000, 8'd0, 9'd15, 3'd6, 1'b0);
      exp_r(DW'(0), SLVERR, 9'd16, 1'b0);
      exp_r(DW'(0), SLVERR, 9'd16, 1'b0);
      exp_r(DW'(0), SLVERR, 9'd16, 1'b1);
      do_read(48'h2000, 8'd2, 9'd16, 3'd3, 1'b0);
      rr_mode = 1'b0;
      rr_level = 1'b1;
      tick();

      // reset during beat 2 of an 8-beat read
      exp_r(DW'(0), OKAY, 9'd17, 1'b0);
      exp_r(DW'(1), OKAY, 9'd17, 1'b0);
      issue_ar(48'h1000, 8'd7, 9'd17, 3'd6);
      n = 0;
      while (rq.size() != 0 && n < 50) begin tick(); n++; end
      chk("rst_test_beats01", DW'(rq.size()), DW'(0));
      rr_level = 1'b0;
      n = 0;
      while (!rvalid && n < 10) begin @(negedge clk); n++; end
      chk("rst_test_beat2_up", DW'(rvalid), DW'(1));
      #1 reset_n = 1'b0;
      #1;
      chk("rst_mid_rvalid", DW'(rvalid), DW'(0));
      chk("rst_mid_arready", DW'(arready), DW'(1));
      chk("rst_mid_rlast_rid", DW'({rlast, rid}), DW'(0));
      rq.delete();
      tick();
      tick();
      reset_n = 1'b1;
      rr_level = 1'b1;
      tick();
      exp_r({64{8'hA5}}, OKAY, 9'd7, 1'b1);
      do_read(48'h40, 8'd0, 9'd7, 3'd6, 1'b1);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
